// File: rtl/nios_system_switch_debounce.sv
// Synchronises and debounces raw slide-switch pins ahead of the switches PIO in_port.
// Define SWITCH_DEBOUNCE_EDGE_EN to add sticky per-bit change flags (edge_capture/edge_clear).
module nios_system_switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_sw_changed;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw[gi]};
                end
            end

            assign w_sync[gi]   = r_sync[SYNC_STAGES-1];
            assign w_differ[gi] = w_sync[gi] ^ r_sw_out[gi];
            assign w_accept[gi] = w_differ[gi] && (r_cnt == CNT_LAST);

            // Any agreeing sample restarts the run; acceptance clears it so it never wraps.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!w_differ[gi] || w_accept[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Accept only fires on disagreement, so toggling the accepted bits loads the synced level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_out     <= '0;
            r_sw_changed <= '0;
        end else begin
            r_sw_out     <= r_sw_out ^ w_accept;
            r_sw_changed <= w_accept;
        end
    end

    assign sw_out     = r_sw_out;
    assign sw_changed = r_sw_changed;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] r_edge_capture;

    // A new change wins over a clear arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_capture <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~edge_clear) | w_accept;
        end
    end

    assign edge_capture = r_edge_capture;
`endif

endmodule

// File: tb/tb_nios_system_switch_debounce.sv
// Scoreboard bench for nios_system_switch_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Outputs are sampled on the falling edge; t counts rising edges since the stimulus change.
module tb_nios_system_switch_debounce;

    typedef struct packed {
        logic [7:0] exp_out;
        logic [7:0] exp_chg;
        logic [7:0] exp_cap;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] sw_raw;
    logic [7:0] sw_out;
    logic [7:0] sw_changed;
    logic [7:0] cap_obs;
    exp_t       sb[$];
    int         checks;
    int         errors;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
    logic [7:0] edge_clear;
    logic [7:0] edge_capture;
    assign cap_obs = edge_capture;
`else
    localparam bit EDGE_EN = 1'b0;
    assign cap_obs = 8'h00;
`endif

    nios_system_switch_debounce #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .sw_out      (sw_out),
        .sw_changed  (sw_changed)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .edge_clear  (edge_clear),
        .edge_capture(edge_capture)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input logic [7:0] v);
        @(negedge clk);
        reset  = 1'b1;
        sw_raw = v;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        edge_clear = 8'h00;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset  = 1'b1;
        sw_raw = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if (sw_out !== 8'h00 || sw_changed !== 8'h00 || cap_obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold sw_out=%h sw_changed=%h edge_capture=%h expected 00 00 00",
                     sw_out, sw_changed, cap_obs);
        end else begin
            $display("reset_hold sw_out=%h sw_changed=%h edge_capture=%h ok", sw_out, sw_changed, cap_obs);
        end
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            e.exp_out = (t >= 6) ? 8'hFF : 8'h00;
            e.exp_chg = (t == 6) ? 8'hFF : 8'h00;
            e.exp_cap = (EDGE_EN && t >= 6) ? 8'hFF : 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg || cap_obs !== e.exp_cap) begin
                errors++;
                $display("FAIL reset_release t=%0d sw_out=%h sw_changed=%h edge_capture=%h expected %h %h %h",
                         t, sw_out, sw_changed, cap_obs, e.exp_out, e.exp_chg, e.exp_cap);
            end else begin
                $display("reset_release t=%0d sw_out=%h sw_changed=%h edge_capture=%h ok",
                         t, sw_out, sw_changed, cap_obs);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset(8'h00);
        sw_raw = 8'h01;
        for (int t = 1; t <= 9; t++) begin
            e.exp_out = (t >= 6) ? 8'h01 : 8'h00;
            e.exp_chg = (t == 6) ? 8'h01 : 8'h00;
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL single t=%0d sw_out=%h sw_changed=%h expected %h %h",
                         t, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("single t=%0d sw_out=%h sw_changed=%h ok", t, sw_out, sw_changed);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        do_reset(8'h00);
        sw_raw = 8'h02;
        for (int t = 1; t <= 12; t++) begin
            e.exp_out = 8'h00;
            e.exp_chg = 8'h00;
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL glitch3 t=%0d sw_out=%h sw_changed=%h expected %h %h",
                         t, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("glitch3 t=%0d sw_out=%h sw_changed=%h ok", t, sw_out, sw_changed);
            end
            if (t == 3) sw_raw = 8'h00;
        end
        // four-cycle pulse is accepted, then its release is accepted four samples later
        sw_raw = 8'h02;
        for (int t = 1; t <= 12; t++) begin
            e.exp_out = (t >= 6 && t < 10) ? 8'h02 : 8'h00;
            e.exp_chg = (t == 6 || t == 10) ? 8'h02 : 8'h00;
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL pulse4 t=%0d sw_out=%h sw_changed=%h expected %h %h",
                         t, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("pulse4 t=%0d sw_out=%h sw_changed=%h ok", t, sw_out, sw_changed);
            end
            if (t == 4) sw_raw = 8'h00;
        end
    endtask

    task automatic test_independent();
        exp_t e;
        do_reset(8'h00);
        sw_raw = 8'h01;
        for (int t = 1; t <= 10; t++) begin
            e.exp_out = ((t >= 6) ? 8'h01 : 8'h00) | ((t >= 8) ? 8'h80 : 8'h00);
            e.exp_chg = ((t == 6) ? 8'h01 : 8'h00) | ((t == 8) ? 8'h80 : 8'h00);
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL independent t=%0d sw_out=%h sw_changed=%h expected %h %h",
                         t, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("independent t=%0d sw_out=%h sw_changed=%h ok", t, sw_out, sw_changed);
            end
            if (t == 2) sw_raw = 8'h81;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset(8'h00);
        sw_raw = 8'h10;
        for (int t = 1; t <= 5; t++) begin
            e.exp_out = 8'h00;
            e.exp_chg = 8'h00;
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL reset_mid t=%0d sw_out=%h sw_changed=%h expected %h %h",
                         t, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("reset_mid t=%0d sw_out=%h sw_changed=%h ok", t, sw_out, sw_changed);
            end
            if (t == 4) reset = 1'b1;
            if (t == 5) reset = 1'b0;
        end
        for (int u = 1; u <= 8; u++) begin
            e.exp_out = (u >= 6) ? 8'h10 : 8'h00;
            e.exp_chg = (u == 6) ? 8'h10 : 8'h00;
            e.exp_cap = 8'h00;
            sb.push_back(e);
        end
        for (int u = 1; u <= 8; u++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg) begin
                errors++;
                $display("FAIL reset_mid_release u=%0d sw_out=%h sw_changed=%h expected %h %h",
                         u, sw_out, sw_changed, e.exp_out, e.exp_chg);
            end else begin
                $display("reset_mid_release u=%0d sw_out=%h sw_changed=%h ok", u, sw_out, sw_changed);
            end
        end
        // reset between clock edges must clear the accepted level without waiting for a clock
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (sw_out !== 8'h00 || sw_changed !== 8'h00) begin
            errors++;
            $display("FAIL async_reset sw_out=%h sw_changed=%h expected 00 00", sw_out, sw_changed);
        end else begin
            $display("async_reset sw_out=%h sw_changed=%h ok", sw_out, sw_changed);
        end
    endtask

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    task automatic test_edge();
        exp_t e;
        do_reset(8'h00);
        sw_raw = 8'h04;
        for (int t = 1; t <= 8; t++) begin
            e.exp_out = (t >= 6) ? 8'h04 : 8'h00;
            e.exp_chg = (t == 6) ? 8'h04 : 8'h00;
            e.exp_cap = (t >= 6) ? 8'h04 : 8'h00;
            sb.push_back(e);
        end
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg || edge_capture !== e.exp_cap) begin
                errors++;
                $display("FAIL edge_set t=%0d sw_out=%h sw_changed=%h edge_capture=%h expected %h %h %h",
                         t, sw_out, sw_changed, edge_capture, e.exp_out, e.exp_chg, e.exp_cap);
            end else begin
                $display("edge_set t=%0d sw_out=%h sw_changed=%h edge_capture=%h ok",
                         t, sw_out, sw_changed, edge_capture);
            end
        end
        sw_raw = 8'h00;
        for (int s = 1; s <= 10; s++) begin
            e.exp_out = (s >= 6) ? 8'h00 : 8'h04;
            e.exp_chg = (s == 6) ? 8'h04 : 8'h00;
            e.exp_cap = (s >= 9) ? 8'h00 : 8'h04;
            sb.push_back(e);
        end
        for (int s = 1; s <= 10; s++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (sw_out !== e.exp_out || sw_changed !== e.exp_chg || edge_capture !== e.exp_cap) begin
                errors++;
                $display("FAIL edge_clear s=%0d sw_out=%h sw_changed=%h edge_capture=%h expected %h %h %h",
                         s, sw_out, sw_changed, edge_capture, e.exp_out, e.exp_chg, e.exp_cap);
            end else begin
                $display("edge_clear s=%0d sw_out=%h sw_changed=%h edge_capture=%h ok",
                         s, sw_out, sw_changed, edge_capture);
            end
            edge_clear = (s == 5 || s == 8) ? 8'h04 : 8'h00;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sw_raw = 8'h00;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        edge_clear = 8'h00;
`endif
        test_reset();
        test_single();
        test_glitch();
        test_independent();
        test_reset_mid();
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        test_edge();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
